// File: rtl/pc_fetch_stage_if.sv
// pc_fetch_stage_if: fetch-stage bus bundle.
// Carries the pipeline control inputs (stall, flush, redirect), the instruction
// memory request/response pair and the IF/ID register contents.
//   master : the fetch stage (drives pc, ifid_*, fetch_count)
//   slave  : the surrounding pipeline / memory (drives control and imem_instr)
interface pc_fetch_stage_if;
    logic        stall;
    logic        flush;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] imem_instr;
    logic [31:0] pc;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic [31:0] fetch_count;

    modport master (
        input  stall, flush, br_taken, br_target, imem_instr,
        output pc, ifid_pc, ifid_pc4, ifid_instr, ifid_valid, fetch_count
    );

    modport slave (
        output stall, flush, br_taken, br_target, imem_instr,
        input  pc, ifid_pc, ifid_pc4, ifid_instr, ifid_valid, fetch_count
    );
endinterface

// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage: RV32I instruction-fetch front end.
// Owns the PC, presents it to instruction memory, and captures the returned
// word into the IF/ID register one edge later. Redirect beats stall; flush
// turns the IF/ID load into a bubble.
// Ports:
//   clk   : pipeline clock, rising edge
//   reset : synchronous, active-high
//   bus   : pc_fetch_stage_if.master (control in, imem in, pc/IF-ID out)
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   reset,
    pc_fetch_stage_if.master       bus
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] CNT_MAX = '1;

    logic [XLEN-1:0] pc_q,         pc_d;
    logic [XLEN-1:0] ifid_pc_q,    ifid_pc_d;
    logic [XLEN-1:0] ifid_pc4_q,   ifid_pc4_d;
    logic [XLEN-1:0] ifid_instr_q, ifid_instr_d;
    logic            ifid_valid_q, ifid_valid_d;
    logic [XLEN-1:0] fetch_cnt_q,  fetch_cnt_d;
    logic [XLEN-1:0] pc_plus4;

    assign pc_plus4 = pc_q + XLEN'(4);

    // Next-state: redirect > stall > normal advance; flush only affects IF/ID.
    always_comb begin
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        fetch_cnt_d  = fetch_cnt_q;

        if (bus.br_taken) begin
            pc_d         = {bus.br_target[XLEN-1:2], 2'b00};
            ifid_pc_d    = '0;
            ifid_pc4_d   = '0;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
        end else if (bus.stall) begin
            if (bus.flush) begin
                ifid_pc_d    = '0;
                ifid_pc4_d   = '0;
                ifid_instr_d = NOP_INSTR;
                ifid_valid_d = 1'b0;
            end
        end else begin
            pc_d = pc_plus4;
            if (bus.flush) begin
                ifid_pc_d    = '0;
                ifid_pc4_d   = '0;
                ifid_instr_d = NOP_INSTR;
                ifid_valid_d = 1'b0;
            end else begin
                ifid_pc_d    = pc_q;
                ifid_pc4_d   = pc_plus4;
                ifid_instr_d = bus.imem_instr;
                ifid_valid_d = 1'b1;
                // Count delivered instructions, pinned at all-ones.
                if (fetch_cnt_q != CNT_MAX) begin
                    fetch_cnt_d = fetch_cnt_q + XLEN'(1);
                end
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            ifid_pc_q    <= '0;
            ifid_pc4_q   <= '0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
            fetch_cnt_q  <= '0;
        end else begin
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            fetch_cnt_q  <= fetch_cnt_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.ifid_pc     = ifid_pc_q;
    assign bus.ifid_pc4    = ifid_pc4_q;
    assign bus.ifid_instr  = ifid_instr_q;
    assign bus.ifid_valid  = ifid_valid_q;
    assign bus.fetch_count = fetch_cnt_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// tb_pc_fetch_stage: directed test-plan sequence with literal expectations,
// then randomized control traffic, all checked every cycle against a
// behavioural model of the fetch stage.
module tb_pc_fetch_stage;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] CINST = 32'h00D4_84B3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pc_fetch_stage_if bus ();

    pc_fetch_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    // Instruction memory: a fixed word, or a pc-dependent word salted per cycle.
    logic        const_mode;
    logic [31:0] salt;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (const_mode) return CINST;
        return (addr * 32'h9E37_79B1) ^ salt;
    endfunction

    assign bus.imem_instr = mem_word(bus.pc);

    // Behavioural model of what the outputs must be after each edge.
    logic [31:0] m_pc, m_ipc, m_ipc4, m_instr;
    logic        m_valid;
    longint      m_cnt;
    logic        check_en = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic st, input logic fl,
                              input logic bt, input logic [31:0] tgt);
        logic [31:0] fetched;
        logic        to_bubble;
        fetched = mem_word(m_pc);
        if (r) begin
            m_pc = 32'h0; m_ipc = 0; m_ipc4 = 0; m_instr = NOP; m_valid = 0; m_cnt = 0;
            return;
        end
        to_bubble = bt || fl;
        if (bt)         m_pc = tgt & ~32'd3;
        else if (!st)   m_pc = m_pc + 32'd4;
        if (to_bubble) begin
            m_ipc = 0; m_ipc4 = 0; m_instr = NOP; m_valid = 0;
        end else if (!st) begin
            m_ipc   = m_pc - 32'd4;   // m_pc has already advanced
            m_ipc4  = m_pc;
            m_instr = fetched;
            m_valid = 1'b1;
            if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
        end
    endtask

    // One clock: drive, take the edge, advance the model, settle.
    task automatic cyc(input logic r, input logic st, input logic fl,
                       input logic bt, input logic [31:0] tgt);
        reset         = r;
        bus.stall     = st;
        bus.flush     = fl;
        bus.br_taken  = bt;
        bus.br_target = tgt;
        @(posedge clk);
        model_edge(r, st, fl, bt, tgt);
        #1;
        salt = $urandom;
        check_en = 1'b1;
    endtask

    task automatic normal(); cyc(0, 0, 0, 0, 32'h0); endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (check_en) begin
            chk("pc",          bus.pc,          m_pc);
            chk("ifid_pc",     bus.ifid_pc,     m_ipc);
            chk("ifid_pc4",    bus.ifid_pc4,    m_ipc4);
            chk("ifid_instr",  bus.ifid_instr,  m_instr);
            chk("ifid_valid",  32'(bus.ifid_valid), 32'(m_valid));
            chk("fetch_count", bus.fetch_count, m_cnt[31:0]);
        end
    end

    initial begin
        m_pc = 0; m_ipc = 0; m_ipc4 = 0; m_instr = NOP; m_valid = 0; m_cnt = 0;
        const_mode = 1'b1;
        salt = 32'h0;

        // Reset and free run with a constant instruction word.
        cyc(1, 0, 0, 0, 0);
        chk("rst_pc",    bus.pc, 32'h0);
        chk("rst_instr", bus.ifid_instr, NOP);
        chk("rst_valid", 32'(bus.ifid_valid), 32'h0);
        chk("rst_cnt",   bus.fetch_count, 32'h0);
        normal();
        chk("run1_pc",    bus.pc, 32'h4);
        chk("run1_ipc",   bus.ifid_pc, 32'h0);
        chk("run1_valid", 32'(bus.ifid_valid), 32'h1);
        chk("run1_instr", bus.ifid_instr, CINST);
        repeat (3) normal();
        chk("run4_pc",  bus.pc, 32'd16);
        chk("run4_ipc", bus.ifid_pc, 32'd12);
        chk("run4_cnt", bus.fetch_count, 32'd4);

        // Stall at pc=8.
        cyc(1, 0, 0, 0, 0);
        repeat (2) normal();
        chk("pre_stall_pc", bus.pc, 32'd8);
        repeat (2) cyc(0, 1, 0, 0, 0);
        chk("stall_pc",  bus.pc, 32'd8);
        chk("stall_ipc", bus.ifid_pc, 32'd4);
        chk("stall_cnt", bus.fetch_count, 32'd2);
        normal();
        chk("rel_pc",  bus.pc, 32'd12);
        chk("rel_ipc", bus.ifid_pc, 32'd8);

        // Redirect with misaligned target.
        cyc(0, 0, 0, 1, 32'h0000_0043);
        chk("br_pc",    bus.pc, 32'h40);
        chk("br_instr", bus.ifid_instr, NOP);
        chk("br_valid", 32'(bus.ifid_valid), 32'h0);
        normal();
        chk("postbr_ipc",   bus.ifid_pc, 32'h40);
        chk("postbr_valid", 32'(bus.ifid_valid), 32'h1);

        // Branch beats stall; flush alone still advances.
        cyc(0, 1, 0, 1, 32'h20);
        chk("brst_pc",    bus.pc, 32'h20);
        chk("brst_valid", 32'(bus.ifid_valid), 32'h0);
        cyc(0, 0, 1, 0, 0);
        chk("flush_pc",    bus.pc, 32'h24);
        chk("flush_instr", bus.ifid_instr, NOP);
        chk("flush_ipc",   bus.ifid_pc, 32'h0);

        // Address wrap.
        cyc(0, 0, 0, 1, 32'hFFFF_FFFF);
        chk("wrap_br_pc", bus.pc, 32'hFFFF_FFFC);
        normal();
        chk("wrap_pc",   bus.pc, 32'h0);
        chk("wrap_ipc",  bus.ifid_pc, 32'hFFFF_FFFC);
        chk("wrap_ipc4", bus.ifid_pc4, 32'h0);

        // Reset overrides stall and branch.
        cyc(1, 1, 1, 1, 32'h1234_5678);
        chk("rst2_pc",    bus.pc, 32'h0);
        chk("rst2_cnt",   bus.fetch_count, 32'h0);
        chk("rst2_valid", 32'(bus.ifid_valid), 32'h0);
        normal();
        chk("rst2_ipc", bus.ifid_pc, 32'h0);
        chk("rst2_nxt", bus.pc, 32'h4);

        // Randomized traffic with pc-dependent memory contents.
        const_mode = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic        r, st, fl, bt;
            logic [31:0] tgt;
            r   = ($urandom_range(0, 99) < 2);
            st  = ($urandom_range(0, 99) < 25);
            fl  = ($urandom_range(0, 99) < 15);
            bt  = ($urandom_range(0, 99) < 10);
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
            cyc(r, st, fl, bt, tgt);
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch_stage.md
Name: pc_fetch_stage

Overview:
Instruction-fetch front end of the 5-stage RV32I pipeline.
- Owns the program counter and drives it to the instruction memory.
- Accepts the combinational instruction word back from that memory.
- Registers fetch results into the IF/ID pipeline register for decode.
- Handles pipeline stall, flush and taken-branch/jump redirect from later stages.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) placed in IF/ID on flush/redirect/reset.

Ports:
clk  input  1  pipeline clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  hold PC and IF/ID contents (from hazard unit)
flush  input  1  replace IF/ID contents with bubble
br_taken  input  1  redirect request from EX (branch taken / jal / jalr)
br_target  input  32  redirect target address
imem_instr  input  32  instruction word returned combinationally for current pc
pc  output  32  current fetch address to instruction memory
ifid_pc  output  32  PC of instruction held in IF/ID
ifid_pc4  output  32  ifid_pc + 4
ifid_instr  output  32  instruction held in IF/ID
ifid_valid  output  1  1 = IF/ID holds a real instruction, 0 = bubble
fetch_count  output  32  number of valid instructions delivered into IF/ID

Behaviour:
- Reset is synchronous, active-high, and sampled only on rising clk.
  - Values: pc=RESET_PC, ifid_pc=0, ifid_pc4=0, ifid_instr=NOP_INSTR, ifid_valid=0, fetch_count=0.
  - reset overrides all other inputs in the same cycle.
- Reset mid-operation discards all in-flight state. The first fetch after reset deasserts is from RESET_PC.
- pc is a register. imem_instr for the current pc is sampled at the next edge, giving 1-cycle latency from pc change to the IF/ID update.
- Per-edge priority, highest first: reset > br_taken > stall > normal.
- br_taken=1:
  - pc <= {br_target[31:2], 2'b00}; the low two bits are always cleared.
  - IF/ID <= bubble: ifid_instr=NOP_INSTR, ifid_valid=0, ifid_pc=0, ifid_pc4=0.
  - Applies even if stall or flush is also asserted.
- stall=1 with br_taken=0:
  - pc holds.
  - If flush=1, IF/ID <= bubble; otherwise IF/ID holds all fields.
- Normal (stall=0, br_taken=0):
  - pc <= pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
  - If flush=1, IF/ID <= bubble.
  - Otherwise IF/ID <= {ifid_pc=pc, ifid_pc4=pc+4, ifid_instr=imem_instr, ifid_valid=1}.
- fetch_count increments by 1 on each edge that loads a valid (ifid_valid=1) new instruction into IF/ID.
  - Does not increment on hold, bubble or reset.
  - Saturates at 32'hFFFF_FFFF.
- ifid_pc4 is registered, not computed combinationally from ifid_pc.
- No combinational path from any input to pc or any ifid_* output; all outputs are registered.
- imem_instr containing X/Z is captured as-is. This block performs no decode.

Test Plan:
- Reset then free-run, imem returns 0x00D484B3 for every address, 4 cycles -> pc 0,4,8,12,16; ifid_pc 0,4,8,12; ifid_valid 1 from 1st edge after reset; fetch_count=4.
- stall=1 for 2 cycles at pc=8 -> pc stays 8, ifid_pc stays 4 with instruction unchanged, fetch_count unchanged; on release pc->12 and ifid_pc->8.
- br_taken=1, br_target=0x0000_0043 at pc=12 -> next pc=0x40, ifid_instr=0x00000013, ifid_valid=0; following edge ifid_pc=0x40, valid=1.
- br_taken=1 and stall=1 together, target 0x20 -> pc=0x20, IF/ID bubble (branch wins); flush=1 alone at pc=0x20 -> pc=0x24, IF/ID bubble.
- Wrap: force pc to 0xFFFF_FFFC via branch, one normal cycle -> pc=0, ifid_pc=0xFFFF_FFFC, ifid_pc4=0.
- Assert reset mid-run with stall=1 and br_taken=1 -> all outputs return to reset values on that edge; next edge fetches from RESET_PC.
